// File: rtl/linebuf_pkg.sv
// Shared constants, kernel-size encodings, scan states and the row-lag helper
// for the line-buffer front end.
package linebuf_pkg;

  localparam int IMG_WIDTH      = 512;
  localparam int IMG_HEIGHT     = 480;
  localparam int WORDS_PER_LINE = IMG_WIDTH / 4;

  localparam logic [1:0] SZ_2X2 = 2'd0;
  localparam logic [1:0] SZ_3X3 = 2'd1;
  localparam logic [1:0] SZ_5X5 = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Rows between the newest row pushed into the line buffer and the window centre.
  function automatic logic [1:0] lag_of(input logic [1:0] size);
    return (size == SZ_5X5) ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/line_scan_controller.sv
// Frame sequencer: streams image rows from memory into the line buffers, then
// walks the centre row presenting one kernel window per pixel with ready/valid.
module line_scan_controller #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 480,
  parameter int MEM_AW     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        size_in,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       lb_datain,
  output logic [8:0]        lb_address,
  output logic [8:0]        lb_vcount,
  output logic              lb_save,
  output logic [1:0]        lb_size,
  output logic              win_valid,
  input  logic              win_ready
);
  import linebuf_pkg::*;

  localparam int WPL = IMG_WIDTH / 4;
  localparam int KW  = $clog2(WPL + 1);

  logic [1:0]    state;
  logic [1:0]    size_q;
  logic [9:0]    in_row;
  logic [KW-1:0] k;
  logic [8:0]    col;
  logic [8:0]    vcount_q;

  logic [9:0] lag;
  logic [9:0] last_row;
  logic       flush;
  logic       size_legal;

  assign lag        = 10'(lag_of(size_q));
  assign last_row   = 10'(IMG_HEIGHT) + lag - 10'd1;
  assign flush      = in_row >= 10'(IMG_HEIGHT);
  assign size_legal = (size_in == SZ_2X2) || (size_in == SZ_3X3) || (size_in == SZ_5X5);

  // LOAD spends one cycle per word plus one so the last read's data can be saved.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      size_q   <= '0;
      in_row   <= '0;
      k        <= '0;
      col      <= '0;
      vcount_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (size_legal) begin
              size_q <= size_in;
              in_row <= '0;
              k      <= '0;
              state  <= ST_LOAD;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_LOAD: begin
          if (k == KW'(WPL)) begin
            k <= '0;
            if (in_row < lag) begin
              in_row <= in_row + 10'd1;
            end else begin
              col      <= '0;
              vcount_q <= 9'(in_row - lag);
              state    <= ST_EMIT;
            end
          end else begin
            k <= k + KW'(1);
          end
        end
        ST_EMIT: begin
          if (win_ready) begin
            if (col == 9'(IMG_WIDTH - 1)) begin
              col <= '0;
              if (in_row == last_row) begin
                state <= ST_DONE;
              end else begin
                in_row <= in_row + 10'd1;
                state  <= ST_LOAD;
              end
            end else begin
              col <= col + 9'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Flush rows push zeros into the line buffer without touching memory.
  always_comb begin
    busy       = (state == ST_LOAD) || (state == ST_EMIT);
    done       = (state == ST_DONE);
    mem_rd     = (state == ST_LOAD) && (k < KW'(WPL)) && !flush;
    mem_addr   = mem_rd ? MEM_AW'(int'(in_row) * WPL + int'(k)) : '0;
    lb_save    = (state == ST_LOAD) && (k != '0);
    lb_datain  = (lb_save && !flush) ? mem_rdata : '0;
    win_valid  = (state == ST_EMIT);
    lb_vcount  = vcount_q;
    lb_size    = (state == ST_IDLE) ? 2'd0 : size_q;
    lb_address = '0;
    if (lb_save) begin
      lb_address = 9'((int'(k) - 1) * 4);
    end else if (win_valid) begin
      lb_address = col;
    end
  end

endmodule

// File: tb/tb_line_scan_controller.sv
// Self-checking bench for line_scan_controller on a reduced 16x6 frame, with a
// behavioural image memory and a scoreboard of reads, saves and windows.
module tb_line_scan_controller;

  localparam int W   = 16;
  localparam int H   = 6;
  localparam int AW  = 16;
  localparam int WPL = W / 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    size_in;
  logic          busy;
  logic          done;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata = '0;
  logic [31:0]   lb_datain;
  logic [8:0]    lb_address;
  logic [8:0]    lb_vcount;
  logic          lb_save;
  logic [1:0]    lb_size;
  logic          win_valid;
  logic          win_ready;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int seed   = 0;
  int cur_lag = 1;
  logic [1:0] cur_size = 2'd1;

  int          rd_q[$];
  logic [40:0] save_q[$];
  logic [17:0] win_q[$];
  int          done_q[$];
  int first_rd, first_save, first_win;
  int busy_cnt, overlap_cnt, order_err, size_err;

  line_scan_controller #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MEM_AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .size_in(size_in),
    .busy(busy), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .lb_datain(lb_datain), .lb_address(lb_address),
    .lb_vcount(lb_vcount), .lb_save(lb_save), .lb_size(lb_size),
    .win_valid(win_valid), .win_ready(win_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pixel(int row, int c);
    return 8'((row + c + seed) & 255);
  endfunction

  function automatic logic [31:0] word_of(int row, int j);
    return {pixel(row, 4*j+3), pixel(row, 4*j+2), pixel(row, 4*j+1), pixel(row, 4*j)};
  endfunction

  // Image memory: one-cycle read latency, garbage whenever no read was issued.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= word_of(int'(mem_addr) / WPL, int'(mem_addr) % WPL);
    else        mem_rdata <= $urandom;
  end

  always @(negedge clk) begin
    if (mem_rd) begin
      if (first_rd < 0) first_rd = cyc;
      rd_q.push_back(int'(mem_addr));
    end
    if (lb_save) begin
      if (first_save < 0) first_save = cyc;
      save_q.push_back({lb_address, lb_datain});
    end
    if (win_valid) begin
      if (first_win < 0) first_win = cyc;
      if (win_ready) begin
        if (save_q.size() != (int'(lb_vcount) + cur_lag + 1) * WPL) order_err++;
        win_q.push_back({lb_vcount, lb_address});
      end
    end
    if (lb_save && win_valid) overlap_cnt++;
    if (busy) begin
      busy_cnt++;
      if (lb_size !== cur_size) size_err++;
    end
    if (done) done_q.push_back(cyc);
  end

  task automatic check_output(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_monitor();
    rd_q.delete(); save_q.delete(); win_q.delete(); done_q.delete();
    first_rd = -1; first_save = -1; first_win = -1;
    busy_cnt = 0; overlap_cnt = 0; order_err = 0; size_err = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_busy"},     busy, 0);
    check_output({tag, "_done"},     done, 0);
    check_output({tag, "_mem_rd"},   mem_rd, 0);
    check_output({tag, "_mem_addr"}, mem_addr, 0);
    check_output({tag, "_datain"},   lb_datain, 0);
    check_output({tag, "_address"},  lb_address, 0);
    check_output({tag, "_vcount"},   lb_vcount, 0);
    check_output({tag, "_save"},     lb_save, 0);
    check_output({tag, "_size"},     lb_size, 0);
    check_output({tag, "_valid"},    win_valid, 0);
  endtask

  // mode 0: ready held, 1: random ready, 2: 10-cycle stall at (1,10), 3: start pulsed in EMIT
  task automatic apply_stimulus(input logic [1:0] size, input int mode);
    int start_cyc, lag, stall_cycles, bad, got_done;
    bit stalled, pulsed;
    logic [40:0] exp_save;
    lag = (size == 2'd3) ? 2 : 1;
    cur_lag = lag;
    cur_size = size;
    stall_cycles = 0;
    stalled = 0;
    pulsed = 0;
    clear_monitor();
    @(posedge clk); #1;
    size_in = size; start = 1'b1; win_ready = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; size_in = 2'($urandom);
    for (int i = 0; i < 4000 && done_q.size() == 0; i++) begin
      start = 1'b0;
      win_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (mode == 2 && !stalled && win_valid && lb_vcount == 9'd1 && lb_address == 9'd10) begin
        stalled = 1;
        stall_cycles = 10;
        win_ready = 1'b0;
        for (int s = 0; s < 10; s++) begin
          check_output("stall_addr", lb_address, 10);
          check_output("stall_valid", win_valid, 1);
          check_output("stall_save", lb_save, 0);
          @(posedge clk); #1;
        end
        win_ready = 1'b1;
        @(posedge clk); #1;
        check_output("resume_addr", lb_address, 11);
      end
      if (mode == 3 && !pulsed && win_valid && lb_vcount == 9'd2 && lb_address == 9'd5) begin
        pulsed = 1;
        start = 1'b1;
        size_in = 2'd3;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check_output("done_seen", done_q.size(), 1);
    repeat (3) @(posedge clk);
    #1;
    check_output("done_pulses", done_q.size(), 1);
    check_output("idle_busy", busy, 0);
    check_output("rd_count", rd_q.size(), H * WPL);
    check_output("save_count", save_q.size(), (H + lag) * WPL);
    check_output("win_count", win_q.size(), H * W);
    bad = -1;
    foreach (rd_q[i]) if (bad < 0 && rd_q[i] != i) bad = i;
    check_output("rd_seq_first_bad", bad, -1);
    bad = -1;
    foreach (save_q[i]) begin
      exp_save = {9'(4 * (i % WPL)), ((i / WPL) < H) ? word_of(i / WPL, i % WPL) : 32'd0};
      if (bad < 0 && save_q[i] !== exp_save) bad = i;
    end
    check_output("save_seq_first_bad", bad, -1);
    bad = -1;
    foreach (win_q[i]) if (bad < 0 && win_q[i] !== {9'(i / W), 9'(i % W)}) bad = i;
    check_output("win_seq_first_bad", bad, -1);
    check_output("first_rd_cyc", first_rd, start_cyc + 1);
    check_output("first_save_cyc", first_save, start_cyc + 2);
    check_output("first_win_cyc", first_win, start_cyc + 1 + (lag + 1) * (WPL + 1));
    check_output("save_valid_overlap", overlap_cnt, 0);
    check_output("load_order", order_err, 0);
    check_output("size_latch", size_err, 0);
    if (mode != 1) begin
      got_done = (done_q.size() > 0) ? done_q[0] : -1;
      check_output("done_cyc", got_done,
                   start_cyc + 1 + (H + lag) * (WPL + 1) + H * W + stall_cycles);
      check_output("busy_cycles", busy_cnt, (H + lag) * (WPL + 1) + H * W + stall_cycles);
    end
  endtask

  task automatic apply_illegal_size();
    int start_cyc, got_done;
    clear_monitor();
    @(posedge clk); #1;
    size_in = 2'd2; start = 1'b1; win_ready = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    check_output("illegal_done_now", done, 1);
    check_output("illegal_busy_now", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    got_done = (done_q.size() > 0) ? done_q[0] : -1;
    check_output("illegal_done_cyc", got_done, start_cyc + 1);
    check_output("illegal_done_pulses", done_q.size(), 1);
    check_output("illegal_rd_count", rd_q.size(), 0);
    check_output("illegal_busy_cnt", busy_cnt, 0);
  endtask

  task automatic apply_reset_mid_frame();
    cur_size = 2'd1;
    cur_lag = 1;
    clear_monitor();
    @(posedge clk); #1;
    size_in = 2'd1; start = 1'b1; win_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2000 && !(win_valid && lb_vcount == 9'd2); i++) begin
      @(posedge clk); #1;
    end
    check_output("pre_reset_vcount", lb_vcount, 2);
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("abort_no_done", done_q.size(), 0);
    check_output("abort_idle", busy, 0);
  endtask

  initial begin
    logic [1:0] sz;
    reset = 1'b1; start = 1'b0; size_in = 2'd0; win_ready = 1'b0;
    clear_monitor();
    #1;
    check_all_zero("por");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    apply_stimulus(2'd1, 0);
    apply_stimulus(2'd3, 0);
    apply_stimulus(2'd0, 2);
    apply_stimulus(2'd1, 3);
    apply_illegal_size();
    apply_reset_mid_frame();
    apply_stimulus(2'd1, 0);
    for (int f = 0; f < 3; f++) begin
      case ($urandom_range(0, 2))
        0:       sz = 2'd0;
        1:       sz = 2'd1;
        default: sz = 2'd3;
      endcase
      seed = int'($urandom_range(0, 255));
      apply_stimulus(sz, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
